// File: rtl/block_normalize_pkg.sv
// Shared constants, types and helpers for the block-floating-point normaliser.
package block_normalize_pkg;

   localparam int unsigned N_FFT     = 64;
   localparam int unsigned LOG2N     = 6;
   localparam int unsigned DIN_W     = 18;
   localparam int unsigned DOUT_W    = 16;
   localparam int unsigned SHIFT_MAX = 8;
   localparam int unsigned HR_W      = 5;  // holds a headroom of 0..DIN_W-1
   localparam int unsigned SH_W      = 4;  // holds a shift of 0..SHIFT_MAX

   typedef logic signed [DIN_W-1:0]  din_t;
   typedef logic signed [DOUT_W-1:0] dout_t;
   typedef logic signed [5:0]        exp_t;
   typedef logic [HR_W-1:0]          hr_t;
   typedef logic [SH_W-1:0]          sh_t;

   typedef enum logic {StWrWaitSof, StWrFill} wr_state_e;
   typedef enum logic {StRdIdle, StRdRead}    rd_state_e;

   // Block exponent such that true value = dout * 2^e.
   function automatic exp_t shift_to_exp(input sh_t s);
      return exp_t'(int'(DIN_W - DOUT_W) - int'(s));
   endfunction

   // Left-justify by s (never overflows because s <= headroom), then truncate to DOUT_W.
   function automatic dout_t normalize(input din_t x, input sh_t s);
      din_t y;
      y = x <<< s;
      return y[DIN_W-1 -: DOUT_W];
   endfunction

endpackage

// File: rtl/block_normalize_if.sv
// Sample-stream bundle: input stream, output stream and the frame error pulse.
interface block_normalize_if;
   import block_normalize_pkg::*;

   logic  din_valid;
   logic  din_ready;
   logic  din_sof;
   din_t  din_real;
   din_t  din_imag;
   logic  dout_valid;
   logic  dout_ready;
   logic  dout_sof;
   logic  dout_eof;
   dout_t dout_real;
   dout_t dout_imag;
   exp_t  dout_exp;
   logic  frame_err;

   // Normaliser side.
   modport slave (
      input  din_valid, din_sof, din_real, din_imag, dout_ready,
      output din_ready, dout_valid, dout_sof, dout_eof, dout_real, dout_imag, dout_exp,
             frame_err
   );

   // Environment side: sample source and sink.
   modport master (
      output din_valid, din_sof, din_real, din_imag, dout_ready,
      input  din_ready, dout_valid, dout_sof, dout_eof, dout_real, dout_imag, dout_exp,
             frame_err
   );

endinterface

// File: rtl/block_normalize_sign_headroom.sv
// Redundant sign-bit counter: leading bits equal to the sign bit, minus one.
module block_normalize_sign_headroom
   import block_normalize_pkg::*;
(
   input  din_t x_i,
   output hr_t  hr_o
);

   // Walk down from below the MSB, counting until the first bit that differs from the sign.
   always_comb begin
      logic run;
      hr_o = '0;
      run  = 1'b1;
      for (int i = DIN_W - 2; i >= 0; i--) begin
         if (run && (x_i[i] == x_i[DIN_W-1])) begin
            hr_o = hr_o + 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/block_normalize.sv
// Receive-side block-floating-point normaliser with ping-pong frame buffering.
module block_normalize
   import block_normalize_pkg::*;
(
   input logic              clk,
   input logic              rst,
   block_normalize_if.slave bus
);

   localparam logic [LOG2N-1:0] LastAddr = LOG2N'(N_FFT - 1);

   wr_state_e             wr_state_q, wr_state_d;
   rd_state_e             rd_state_q, rd_state_d;
   logic                  rdy_en_q;
   logic                  wr_bank_q, wr_bank_d;
   logic [LOG2N-1:0]      wr_cnt_q, wr_cnt_d;
   hr_t                   hmin_q, hmin_d;
   logic [1:0]            full_q, full_d, full_set, full_clr;
   logic [1:0][SH_W-1:0]  shift_q, shift_d;
   logic                  frame_err_q, frame_err_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0]      rd_cnt_q, rd_cnt_d;
   logic                  dvalid_q, dvalid_d, dsof_q, dsof_d, deof_q, deof_d;
   dout_t                 dre_q, dre_d, dim_q, dim_d;
   exp_t                  dexp_q, dexp_d;

   logic [2*DIN_W-1:0]    mem_q [2][N_FFT];
   logic                  mem_we;
   logic [LOG2N-1:0]      mem_waddr;

   hr_t                   hr_re, hr_im, hr_smp, hmin_acc;
   logic                  din_ready, din_fire, dout_fire;
   logic                  rd_load, rd_load_bank, rd_other, rd_other_full;
   logic [LOG2N-1:0]      rd_load_addr;
   logic [2*DIN_W-1:0]    rd_word;

   block_normalize_sign_headroom u_hr_re (
      .x_i  (bus.din_real),
      .hr_o (hr_re)
   );

   block_normalize_sign_headroom u_hr_im (
      .x_i  (bus.din_imag),
      .hr_o (hr_im)
   );

   assign hr_smp    = (hr_re < hr_im) ? hr_re : hr_im;
   assign hmin_acc  = (hr_smp < hmin_q) ? hr_smp : hmin_q;
   assign din_ready = rdy_en_q && !full_q[wr_bank_q];
   assign din_fire  = bus.din_valid && din_ready;
   assign dout_fire = dvalid_q && bus.dout_ready;
   assign full_d    = (full_q | full_set) & ~full_clr;

   // Write FSM: frame capture, running headroom minimum and bank hand-off.
   always_comb begin
      wr_state_d  = wr_state_q;
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      hmin_d      = hmin_q;
      shift_d     = shift_q;
      full_set    = 2'b00;
      frame_err_d = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = wr_cnt_q;
      if (din_fire) begin
         unique case (wr_state_q)
            StWrWaitSof: begin
               if (bus.din_sof) begin
                  mem_we     = 1'b1;
                  mem_waddr  = '0;
                  hmin_d     = hr_smp;
                  wr_cnt_d   = LOG2N'(1);
                  wr_state_d = StWrFill;
               end
            end
            StWrFill: begin
               mem_we = 1'b1;
               if (bus.din_sof) begin
                  // Restart: the partial frame is dropped and this sample becomes addr 0.
                  frame_err_d = 1'b1;
                  mem_waddr   = '0;
                  hmin_d      = hr_smp;
                  wr_cnt_d    = LOG2N'(1);
               end else begin
                  hmin_d   = hmin_acc;
                  wr_cnt_d = wr_cnt_q + 1'b1;
                  if (wr_cnt_q == LastAddr) begin
                     full_set[wr_bank_q] = 1'b1;
                     shift_d[wr_bank_q]  = (hmin_acc > HR_W'(SHIFT_MAX)) ?
                                           SH_W'(SHIFT_MAX) : SH_W'(hmin_acc);
                     wr_bank_d  = ~wr_bank_q;
                     wr_cnt_d   = '0;
                     wr_state_d = StWrWaitSof;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Read FSM: walks the full bank into the output register, chaining frames without gaps.
   always_comb begin
      rd_state_d    = rd_state_q;
      rd_bank_d     = rd_bank_q;
      rd_cnt_d      = rd_cnt_q;
      full_clr      = 2'b00;
      rd_load       = 1'b0;
      rd_load_bank  = rd_bank_q;
      rd_load_addr  = '0;
      rd_other      = ~rd_bank_q;
      rd_other_full = full_q[rd_other] || full_set[rd_other];
      dvalid_d      = dvalid_q;
      dsof_d        = dsof_q;
      deof_d        = deof_q;
      dre_d         = dre_q;
      dim_d         = dim_q;
      dexp_d        = dexp_q;
      unique case (rd_state_q)
         StRdIdle: begin
            if (full_q[rd_bank_q]) begin
               rd_load    = 1'b1;
               rd_cnt_d   = '0;
               rd_state_d = StRdRead;
            end
         end
         StRdRead: begin
            if (dout_fire) begin
               if (rd_cnt_q == LastAddr) begin
                  rd_bank_d = rd_other;
                  if (rd_other_full) begin
                     rd_load      = 1'b1;
                     rd_load_bank = rd_other;
                     rd_cnt_d     = '0;
                  end else begin
                     dvalid_d   = 1'b0;
                     dsof_d     = 1'b0;
                     deof_d     = 1'b0;
                     rd_state_d = StRdIdle;
                  end
               end else begin
                  rd_load      = 1'b1;
                  rd_load_addr = rd_cnt_q + 1'b1;
                  rd_cnt_d     = rd_cnt_q + 1'b1;
                  // Once the last sample sits in the output register the bank can be refilled.
                  if (rd_load_addr == LastAddr) begin
                     full_clr[rd_bank_q] = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
      rd_word = mem_q[rd_load_bank][rd_load_addr];
      if (rd_load) begin
         dvalid_d = 1'b1;
         dsof_d   = (rd_load_addr == '0);
         deof_d   = (rd_load_addr == LastAddr);
         dre_d    = normalize(din_t'(rd_word[2*DIN_W-1 -: DIN_W]), shift_d[rd_load_bank]);
         dim_d    = normalize(din_t'(rd_word[DIN_W-1:0]), shift_d[rd_load_bank]);
         dexp_d   = shift_to_exp(shift_d[rd_load_bank]);
      end
   end

   // State, flag and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_en_q    <= 1'b0;
         wr_state_q  <= StWrWaitSof;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         hmin_q      <= '0;
         full_q      <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         rd_state_q  <= StRdIdle;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         dvalid_q    <= 1'b0;
         dsof_q      <= 1'b0;
         deof_q      <= 1'b0;
         dre_q       <= '0;
         dim_q       <= '0;
         dexp_q      <= '0;
      end else begin
         rdy_en_q    <= 1'b1;
         wr_state_q  <= wr_state_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         hmin_q      <= hmin_d;
         full_q      <= full_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         rd_state_q  <= rd_state_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         dvalid_q    <= dvalid_d;
         dsof_q      <= dsof_d;
         deof_q      <= deof_d;
         dre_q       <= dre_d;
         dim_q       <= dim_d;
         dexp_q      <= dexp_d;
      end
   end

   // Frame storage; contents need no reset because the full flags gate every read.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[wr_bank_q][mem_waddr] <= {bus.din_real, bus.din_imag};
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.dout_valid = dvalid_q;
   assign bus.dout_sof   = dsof_q;
   assign bus.dout_eof   = deof_q;
   assign bus.dout_real  = dre_q;
   assign bus.dout_imag  = dim_q;
   assign bus.dout_exp   = dexp_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_block_normalize.sv
// Directed bench for block_normalize: hand-computed frames, flow control, restart and reset.
module tb_block_normalize;
   import block_normalize_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   block_normalize_if bus ();

   block_normalize dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int re;
      int im;
      int ex;
      bit sof;
      bit eof;
      int cyc;
   } out_t;

   out_t oq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   ferr_cnt = 0;
   int   stalls   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      out_t o;
      if (rst === 1'b0) begin
         if (bus.dout_valid && bus.dout_ready) begin
            o.re  = $signed(bus.dout_real);
            o.im  = $signed(bus.dout_imag);
            o.ex  = $signed(bus.dout_exp);
            o.sof = bus.dout_sof;
            o.eof = bus.dout_eof;
            o.cyc = cyc;
            oq.push_back(o);
         end
         if (bus.frame_err) ferr_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input bit sof, input int re, input int im);
      int n = 0;
      bus.din_valid = 1'b1;
      bus.din_sof   = sof;
      bus.din_real  = din_t'(re);
      bus.din_imag  = din_t'(im);
      @(negedge clk);
      while (!bus.din_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      stalls += n;
      if (n >= 500) check_eq("din_timeout", n, 0);
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.din_sof   = 1'b0;
   endtask

   task automatic send_frame(input int re0, input int re_step, input int im0, input int im_step);
      for (int i = 0; i < N_FFT; i++) send(i == 0, re0 + i * re_step, im0 + i * im_step);
   endtask

   task automatic wait_out(input int n, input string tag);
      int k = 0;
      while (oq.size() < n && k < 3000) begin
         @(posedge clk);
         k++;
      end
      #1;
      check_eq(tag, oq.size(), n);
   endtask

   // Counts entries [lo, lo+64) that differ from a constant frame.
   function automatic int frame_bad(input int lo, input int re, input int im, input int ex);
      int bad = 0;
      for (int i = 0; i < N_FFT; i++) begin
         if (lo + i >= oq.size()) begin
            bad++;
         end else if (oq[lo+i].re != re || oq[lo+i].im != im || oq[lo+i].ex != ex ||
                      oq[lo+i].sof != (i == 0) || oq[lo+i].eof != (i == N_FFT - 1)) begin
            bad++;
         end
      end
      return bad;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst            = 1'b1;
      bus.din_valid  = 1'b0;
      bus.din_sof    = 1'b0;
      bus.din_real   = '0;
      bus.din_imag   = '0;
      bus.dout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_din_ready", bus.din_ready, 0);
      check_eq("rst_dout_valid", bus.dout_valid, 0);
      check_eq("rst_frame_err", bus.frame_err, 0);
      check_eq("rst_dout_exp", $signed(bus.dout_exp), 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready_lag", bus.din_ready, 0);
      @(posedge clk);
      #1;
      check_eq("rst_ready_rise", bus.din_ready, 1);

      // 1: constant 1000 -> h=7, s=7, 32000, exp -5; one-cycle latency.
      bus.dout_ready = 1'b1;
      send_frame(1000, 0, 1000, 0);
      check_eq("t1_lat_before", bus.dout_valid, 0);
      @(posedge clk);
      #1;
      check_eq("t1_lat_after", bus.dout_valid, 1);
      wait_out(64, "t1_count");
      check_eq("t1_first_re", oq[0].re, 32000);
      check_eq("t1_first_exp", oq[0].ex, -5);
      check_eq("t1_frame", frame_bad(0, 32000, 32000, -5), 0);
      oq.delete();

      // 2: full-scale sample forces s=0.
      send(1'b1, -131072, 0);
      for (int i = 1; i < N_FFT; i++) send(1'b0, 4000, -4000);
      wait_out(64, "t2_count");
      check_eq("t2_re0", oq[0].re, -32768);
      check_eq("t2_im0", oq[0].im, 0);
      check_eq("t2_exp", oq[0].ex, 2);
      check_eq("t2_re1", oq[1].re, 1000);
      check_eq("t2_im1", oq[1].im, -1000);
      check_eq("t2_eof", oq[63].eof, 1);
      oq.delete();

      // 3: all-zero frame clamps to SHIFT_MAX.
      send_frame(0, 0, 0, 0);
      wait_out(64, "t3_count");
      check_eq("t3_frame", frame_bad(0, 0, 0, -6), 0);
      oq.delete();

      // 4: three back-to-back frames, no output gaps, no input stalls.
      stalls = 0;
      send_frame(1000, 0, 1000, 0);
      send_frame(2000, 0, -2000, 0);
      send_frame(100, 0, 50, 0);
      wait_out(192, "t4_count");
      check_eq("t4_stalls", stalls, 0);
      bad = 0;
      for (int i = 1; i < oq.size(); i++) if (oq[i].cyc != oq[i-1].cyc + 1) bad++;
      check_eq("t4_gaps", bad, 0);
      check_eq("t4_f0", frame_bad(0, 32000, 32000, -5), 0);
      check_eq("t4_f1", frame_bad(64, 32000, -32000, -4), 0);
      check_eq("t4_f2", frame_bad(128, 6400, 3200, -6), 0);
      oq.delete();

      // 5: downstream stalled while two frames arrive.
      bus.dout_ready = 1'b0;
      stalls = 0;
      send_frame(1, 1, -1, -1);
      send_frame(2000, 0, -2000, 0);
      check_eq("t5_stalls", stalls, 0);
      check_eq("t5_ready_low", bus.din_ready, 0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("t5_hold_valid", bus.dout_valid, 1);
      check_eq("t5_hold_re", $signed(bus.dout_real), 64);
      check_eq("t5_hold_sof", bus.dout_sof, 1);
      bus.dout_ready = 1'b1;
      wait_out(128, "t5_count");
      bad = 0;
      for (int i = 0; i < N_FFT && i < oq.size(); i++) begin
         if (oq[i].re != (i + 1) * 64 || oq[i].im != -(i + 1) * 64 || oq[i].ex != -6) bad++;
      end
      check_eq("t5_fa", bad, 0);
      check_eq("t5_fb", frame_bad(64, 32000, -32000, -4), 0);
      oq.delete();

      // 6: sof reissued at sample 30; partial frame must not affect the shift.
      ferr_cnt = 0;
      send(1'b1, -131072, -131072);
      for (int i = 1; i < 30; i++) send(1'b0, -131072, 5);
      send_frame(2000, 0, -2000, 0);
      wait_out(64, "t6_count");
      repeat (5) @(posedge clk);
      #1;
      check_eq("t6_ferr", ferr_cnt, 1);
      check_eq("t6_only_one", oq.size(), 64);
      check_eq("t6_frame", frame_bad(0, 32000, -32000, -4), 0);
      oq.delete();

      // Reset while a frame is being read out.
      bus.dout_ready = 1'b0;
      send_frame(1000, 0, 1000, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("t6_pre_valid", bus.dout_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t6_rst_valid", bus.dout_valid, 0);
      check_eq("t6_rst_ready", bus.din_ready, 0);
      rst = 1'b0;
      bus.dout_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_eq("t6_flushed", oq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
